comparador_pwm_multi: RTL and testbench

COMPARADOR_PWM_MULTI -- requirements
Module: comparador_pwm_multi

---
 rtl/comparador_pwm_multi.sv | 83 ++++++++
 tb/tb_comparador_pwm_multi.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/comparador_pwm_multi.sv
// ----------------------------------------------------------------------------
// comparador_pwm_multi: shared PWM counter, double-buffered multi-channel compare
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module comparador_pwm_multi #(
  parameter int WIDTH    = 10,
  parameter int CHANNELS = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic [WIDTH-1:0]    period,
  input  logic                load,
  input  logic [3:0]          ch_sel,
  input  logic [WIDTH-1:0]    duty_in,
  input  logic [CHANNELS-1:0] pol,
  output logic [WIDTH-1:0]    count,
  output logic                wrap,
  output logic [CHANNELS-1:0] comp
);

  logic [WIDTH-1:0]    count_q, count_d;
  logic                wrap_q, wrap_d;
  logic [CHANNELS-1:0] comp_q, comp_d;
  logic [WIDTH-1:0]    pend_q [CHANNELS];
  logic [WIDTH-1:0]    pend_d [CHANNELS];
  logic [WIDTH-1:0]    act_q  [CHANNELS];
  logic [WIDTH-1:0]    act_d  [CHANNELS];
  logic                rollover;

  always_comb begin
    rollover = en & (count_q >= period);
    count_d  = count_q;
    wrap_d   = rollover;
    comp_d   = comp_q;
    if (en) begin
      count_d = rollover ? '0 : count_q + WIDTH'(1);
    end
    for (int i = 0; i < CHANNELS; i++) begin
      pend_d[i] = pend_q[i];
      if (load && (ch_sel == 4'(i))) begin
        pend_d[i] = duty_in;
      end
      // Take the post-write pending value so a load on the rollover edge is forwarded.
      act_d[i] = act_q[i];
      if (!en || rollover) begin
        act_d[i] = pend_d[i];
      end
      if (en) begin
        comp_d[i] = (count_q < act_q[i]) ^ pol[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
      comp_q  <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        pend_q[i] <= '0;
        act_q[i]  <= '0;
      end
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      comp_q  <= comp_d;
      for (int i = 0; i < CHANNELS; i++) begin
        pend_q[i] <= pend_d[i];
        act_q[i]  <= act_d[i];
      end
    end
  end

  assign count = count_q;
  assign wrap  = wrap_q;
  assign comp  = comp_q;

endmodule

`default_nettype wire

// File: tb/tb_comparador_pwm_multi.sv
// ----------------------------------------------------------------------------
// tb_comparador_pwm_multi: directed scenarios with a cycle scoreboard
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_comparador_pwm_multi;

  logic       clk = 1'b0;
  logic       reset, en, load;
  logic [9:0] period, duty_in;
  logic [3:0] ch_sel, pol;
  logic [9:0] count;
  logic       wrap;
  logic [3:0] comp;

  comparador_pwm_multi #(.WIDTH(10), .CHANNELS(4)) dut (
    .clk(clk), .reset(reset), .en(en), .period(period), .load(load),
    .ch_sel(ch_sel), .duty_in(duty_in), .pol(pol),
    .count(count), .wrap(wrap), .comp(comp)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0] c;
    logic       w;
    logic [3:0] p;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  int         hi[4];
  int         nwrap;
  logic [9:0] m_count, m_pend[4], m_act[4];
  logic       m_wrap;
  logic [3:0] m_comp;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic clr();
    nwrap = 0;
    for (int i = 0; i < 4; i++) hi[i] = 0;
  endtask

  // Reference behaviour evaluated on the inputs present at the coming edge.
  task automatic tick();
    exp_t       e;
    logic       roll;
    logic [9:0] pn[4];
    if (reset) begin
      m_count = 0; m_wrap = 0; m_comp = 0;
      for (int i = 0; i < 4; i++) begin m_pend[i] = 0; m_act[i] = 0; end
    end else begin
      roll = en && (m_count >= period);
      for (int i = 0; i < 4; i++) begin
        pn[i] = m_pend[i];
        if (load && ch_sel == 4'(i)) pn[i] = duty_in;
      end
      if (en) for (int i = 0; i < 4; i++) m_comp[i] = (m_count < m_act[i]) ^ pol[i];
      for (int i = 0; i < 4; i++) begin
        if (!en || roll) m_act[i] = pn[i];
        m_pend[i] = pn[i];
      end
      m_wrap = roll;
      if (en) m_count = roll ? 10'd0 : m_count + 10'd1;
    end
    sb.push_back('{c: m_count, w: m_wrap, p: m_comp});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("count", 32'(count), 32'(e.c));
    chk("wrap",  32'(wrap),  32'(e.w));
    chk("comp",  32'(comp),  32'(e.p));
    if (wrap) nwrap++;
    for (int i = 0; i < 4; i++) if (comp[i]) hi[i]++;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic ld(input logic [3:0] ch, input logic [9:0] val);
    load = 1'b1; ch_sel = ch; duty_in = val;
    tick();
    load = 1'b0;
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; load = 1'b0; period = 10'd0;
    ch_sel = 4'd0; duty_in = 10'd0; pol = 4'b0000;
    clr();
    run(2);
    chk("rst_count", 32'(count), 0);
    chk("rst_wrap",  32'(wrap),  0);
    chk("rst_comp",  32'(comp),  0);

    // 725/1000 duty on ch0, loaded while idle
    reset = 1'b0; period = 10'd999;
    ld(4'd0, 10'd725);
    en = 1'b1;
    clr(); run(2000);
    chk("ch0_725_high", hi[0], 1450);
    chk("wrap_2000", nwrap, 2);

    // mid-period reload keeps old width until the next period
    ld(4'd1, 10'd200); run(999);
    clr(); run(500); ld(4'd1, 10'd600); run(499);
    chk("ch1_old_width", hi[1], 200);
    clr(); run(1000);
    chk("ch1_new_width", hi[1], 600);
    chk("ch0_unchanged", hi[0], 725);
    chk("wrap_1000", nwrap, 1);

    // duty 0 inverted and duty above period
    pol = 4'b0100;
    ld(4'd2, 10'd0); ld(4'd3, 10'd1023); run(998);
    clr(); run(1000);
    chk("ch2_inv_zero", hi[2], 1000);
    chk("ch3_full", hi[3], 1000);
    pol = 4'b0000;
    clr(); run(1000);
    chk("ch2_zero", hi[2], 0);
    chk("ch3_full2", hi[3], 1000);

    // load on the rollover edge is forwarded
    run(999); ld(4'd0, 10'd100);
    clr(); run(1000);
    chk("fwd_ch0", hi[0], 100);

    // out-of-range channel write is ignored
    ld(4'd7, 10'd5); run(999);
    clr(); run(1000);
    chk("sel7_ch0", hi[0], 100);
    chk("sel7_ch1", hi[1], 600);
    chk("sel7_ch2", hi[2], 0);
    chk("sel7_ch3", hi[3], 1000);

    // period lowered below the running count
    run(500);
    chk("cnt500", 32'(count), 500);
    period = 10'd100; tick();
    chk("lower_count", 32'(count), 0);
    chk("lower_wrap",  32'(wrap),  1);
    clr(); run(202);
    chk("p100_wraps", nwrap, 2);

    // period 0: stuck at 0, wrap every cycle
    period = 10'd0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("p0_count", 32'(count), 0);
      chk("p0_wrap",  32'(wrap),  1);
    end

    // reset mid-operation clears everything
    period = 10'd999; run(300);
    chk("cnt300", 32'(count), 300);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("mid_rst_count", 32'(count), 0);
    chk("mid_rst_wrap",  32'(wrap),  0);
    chk("mid_rst_comp",  32'(comp),  0);
    tick();
    chk("restart_count", 32'(count), 1);
    chk("restart_wrap",  32'(wrap),  0);
    clr(); run(1000);
    for (int i = 0; i < 4; i++) chk("duty_cleared", hi[i], 0);

    // disabled: state holds, duty writes act immediately
    en = 1'b0; run(3);
    ld(4'd0, 10'd400);
    en = 1'b1;
    clr(); run(1000);
    chk("idle_load_ch0", hi[0], 400);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
